// File: rtl/xconf_bank.sv
// xconf_bank: banked configuration register.
// Holds a shadow image written by the controller, an active image driven onto
// conf_out, and a small store of saved images moved one field per cycle.
module xconf_bank #(
  parameter int N_FIELDS = 8,
  parameter int FIELD_W  = 16,
  parameter int N_SLOTS  = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ctr_valid,
  input  logic                        ctr_we,
  input  logic [ADDR_W-1:0]           ctr_addr,
  input  logic [DATA_W-1:0]           ctr_data_in,
  output logic                        ctr_ready,
  output logic                        ctr_rvalid,
  output logic [DATA_W-1:0]           ctr_data_out,
  output logic                        busy,
  output logic                        conf_upd,
  output logic [N_FIELDS*FIELD_W-1:0] conf_out
);

  localparam int CNT_W  = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
  localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  localparam logic [ADDR_W-1:0] A_CLEAR  = ADDR_W'(N_FIELDS);
  localparam logic [ADDR_W-1:0] A_SAVE   = ADDR_W'(N_FIELDS + 1);
  localparam logic [ADDR_W-1:0] A_LOAD   = ADDR_W'(N_FIELDS + 2);
  localparam logic [ADDR_W-1:0] A_COMMIT = ADDR_W'(N_FIELDS + 3);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(N_FIELDS + 4);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N_FIELDS - 1);

  typedef enum logic [1:0] {IDLE, SAVE, LOAD} state_t;

  state_t              state;
  logic [FIELD_W-1:0]  shadow [N_FIELDS];
  logic [FIELD_W-1:0]  active [N_FIELDS];
  logic [FIELD_W-1:0]  store  [N_SLOTS][N_FIELDS];
  logic [CNT_W-1:0]    idx;
  logic [SLOT_W-1:0]   slot;
  logic [SLOT_W-1:0]   last_slot;
  logic                err;

  logic                accept;
  logic                is_field;
  logic                slot_ok;
  logic [CNT_W-1:0]    field_sel;
  logic [DATA_W-1:0]   rd_word;

  // The copy engine owns the shadow and store while it runs, so requests stall.
  assign busy      = (state != IDLE);
  assign ctr_ready = !busy;
  assign accept    = ctr_valid && ctr_ready;
  assign is_field  = (ctr_addr < A_CLEAR);
  assign field_sel = ctr_addr[CNT_W-1:0];
  assign slot_ok   = (ctr_data_in < DATA_W'(N_SLOTS));

  // Active image fields are packed with field 0 at the LSBs.
  for (genvar k = 0; k < N_FIELDS; k++) begin : g_conf
    assign conf_out[k*FIELD_W +: FIELD_W] = active[k];
  end

  // Read data mux: shadow fields zero-extended, STATUS word, zero elsewhere.
  always_comb begin
    rd_word = '0;
    if (is_field) begin
      rd_word[FIELD_W-1:0] = shadow[field_sel];
    end else if (ctr_addr == A_STATUS) begin
      rd_word[0]          = busy;
      rd_word[1]          = err;
      rd_word[2 +: SLOT_W] = last_slot;
    end
  end

  // Read response is registered and presented for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_rvalid   <= 1'b0;
      ctr_data_out <= '0;
    end else if (accept && !ctr_we) begin
      ctr_rvalid   <= 1'b1;
      ctr_data_out <= rd_word;
    end else begin
      ctr_rvalid   <= 1'b0;
      ctr_data_out <= '0;
    end
  end

  // Command decode and field-serial copy engine; active only moves as a whole image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      slot      <= '0;
      last_slot <= '0;
      err       <= 1'b0;
      conf_upd  <= 1'b0;
      for (int k = 0; k < N_FIELDS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      for (int s = 0; s < N_SLOTS; s++) begin
        for (int k = 0; k < N_FIELDS; k++) begin
          store[s][k] <= '0;
        end
      end
    end else begin
      conf_upd <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (ctr_we) begin
              if (is_field) begin
                shadow[field_sel] <= ctr_data_in[FIELD_W-1:0];
              end else if (ctr_addr == A_CLEAR) begin
                for (int k = 0; k < N_FIELDS; k++) begin
                  shadow[k] <= '0;
                  active[k] <= '0;
                end
                conf_upd <= 1'b1;
              end else if (ctr_addr == A_COMMIT) begin
                for (int k = 0; k < N_FIELDS; k++) begin
                  active[k] <= shadow[k];
                end
                conf_upd <= 1'b1;
              end else if ((ctr_addr == A_SAVE) || (ctr_addr == A_LOAD)) begin
                if (slot_ok) begin
                  slot      <= ctr_data_in[SLOT_W-1:0];
                  last_slot <= ctr_data_in[SLOT_W-1:0];
                  idx       <= '0;
                  state     <= (ctr_addr == A_SAVE) ? SAVE : LOAD;
                end else begin
                  err <= 1'b1;
                end
              end
            end else if (ctr_addr == A_STATUS) begin
              err <= 1'b0;
            end
          end
        end
        SAVE: begin
          store[slot][idx] <= shadow[idx];
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state <= IDLE;
          end
        end
        LOAD: begin
          shadow[idx] <= store[slot][idx];
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state <= IDLE;
            for (int k = 0; k < N_FIELDS; k++) begin
              active[k] <= store[slot][k];
            end
            conf_upd <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
